// File: rtl/ex_mul_stage_pkg.sv
// Shared encodings and types for the EX stage with its iterative multiplier.
// Holds the ALU opcodes, the forwarding selects and the multiplier FSM states.
package ex_mul_stage_pkg;

  localparam int MUL_CYCLES = 32;
  localparam int CNT_W      = $clog2(MUL_CYCLES);

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_XOR  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_ADDI = 3'b110,
    ALU_SRAI = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

endpackage

// File: rtl/ex_mul_stage_mul.sv
// Shift-add multiplier: one partial product per step, low DATA_W bits kept.
// Two's-complement wrap makes the low word correct for signed operands too.
module mul_iter
  import ex_mul_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] product,
  output logic              last
);

  logic signed [DATA_W-1:0] a_q;
  logic        [DATA_W-1:0] b_q;
  logic signed [DATA_W-1:0] acc_q;
  logic        [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      a_q   <= op_a;
      b_q   <= op_b;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step) begin
      if (b_q[0]) begin
        acc_q <= acc_q + a_q;
      end
      a_q   <= a_q <<< 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign product = acc_q;
  assign last    = (cnt_q == CNT_W'(MUL_CYCLES - 1));

endmodule

// File: rtl/ex_mul_stage.sv
// EX stage: operand forwarding, single-cycle ALU, multi-cycle MUL with stall,
// and the EX/MEM pipeline register.
module ex_mul_stage
  import ex_mul_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic              ALUSrc_i,
  input  logic [2:0]        ALUCtrl_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [4:0]        Rd_i,
  input  logic [1:0]        Forward_A_i,
  input  logic [1:0]        Forward_B_i,
  input  logic [DATA_W-1:0] MEM_ALUResult_i,
  input  logic [DATA_W-1:0] WB_WriteData_i,
  output logic              Stall_o,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic [DATA_W-1:0] MemData_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [4:0]        Rd_o
);

  function automatic logic signed [DATA_W-1:0] fwd_pick(
    input logic [1:0]               sel,
    input logic signed [DATA_W-1:0] reg_v,
    input logic signed [DATA_W-1:0] mem_v,
    input logic signed [DATA_W-1:0] wb_v
  );
    case (sel)
      FWD_MEM: fwd_pick = mem_v;
      FWD_WB:  fwd_pick = wb_v;
      default: fwd_pick = reg_v;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] alu_op(
    input logic [2:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    case (op)
      ALU_AND:           alu_op = a & b;
      ALU_XOR:           alu_op = a ^ b;
      ALU_SLL:           alu_op = a << b[4:0];
      ALU_ADD, ALU_ADDI: alu_op = a + b;
      ALU_SUB:           alu_op = a - b;
      ALU_SRAI:          alu_op = a >>> b[4:0];
      default:           alu_op = '0;
    endcase
  endfunction

  mul_state_e state_q, state_d;

  logic signed [DATA_W-1:0] fwd_a_p0, fwd_b_p0, op_b_p0, alu_res_p0;
  logic                     mul_req, mul_start, mul_step, mul_last;
  logic        [DATA_W-1:0] mul_product;
  ex_ctrl_t                 ctrl_p0, held_ctrl, ctrl_p1;
  logic        [4:0]        held_rd;
  logic        [DATA_W-1:0] held_store;

  // EX stage (p0): forwarding muxes and single-cycle ALU
  assign fwd_a_p0   = fwd_pick(Forward_A_i, RS1data_i, MEM_ALUResult_i, WB_WriteData_i);
  assign fwd_b_p0   = fwd_pick(Forward_B_i, RS2data_i, MEM_ALUResult_i, WB_WriteData_i);
  assign op_b_p0    = ALUSrc_i ? Imm_i : fwd_b_p0;
  assign alu_res_p0 = alu_op(ALUCtrl_i, fwd_a_p0, op_b_p0);
  assign mul_req    = (ALUCtrl_i == ALU_MUL);
  assign ctrl_p0    = '{reg_write: RegWrite_i, mem_to_reg: MemtoReg_i,
                        mem_read: MemRead_i, mem_write: MemWrite_i};

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= MUL_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    Stall_o   = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        if (mul_req) begin
          Stall_o   = 1'b1;
          mul_start = 1'b1;
          state_d   = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        Stall_o  = 1'b1;
        mul_step = 1'b1;
        if (mul_last) state_d = MUL_DONE;
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .start   (mul_start),
    .step    (mul_step),
    .op_a    (fwd_a_p0),
    .op_b    (op_b_p0),
    .product (mul_product),
    .last    (mul_last)
  );

  // The MUL's own ID/EX fields are captured at start so DONE never depends on
  // what the held ID/EX register or the forwarding paths show later.
  always_ff @(posedge clk_i) begin
    if (!rst_i)         held_ctrl <= '0;
    else if (mul_start) held_ctrl <= ctrl_p0;
  end

  always_ff @(posedge clk_i) begin
    if (mul_start) begin
      held_rd    <= Rd_i;
      held_store <= fwd_b_p0;
    end
  end

  // EX/MEM boundary (p1)
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ctrl_p1     <= '0;
      ALUResult_o <= '0;
      MemData_o   <= '0;
      Rd_o        <= '0;
    end else if (Stall_o) begin
      ctrl_p1 <= '0;
    end else if (state_q == MUL_DONE) begin
      ctrl_p1     <= held_ctrl;
      ALUResult_o <= mul_product;
      MemData_o   <= held_store;
      Rd_o        <= held_rd;
    end else begin
      ctrl_p1     <= ctrl_p0;
      ALUResult_o <= alu_res_p0;
      MemData_o   <= fwd_b_p0;
      Rd_o        <= Rd_i;
    end
  end

  assign RegWrite_o = ctrl_p1.reg_write;
  assign MemtoReg_o = ctrl_p1.mem_to_reg;
  assign MemRead_o  = ctrl_p1.mem_read;
  assign MemWrite_o = ctrl_p1.mem_write;

endmodule

// File: tb/tb_ex_mul_stage.sv
// Directed bench for ex_mul_stage: expected results are queued at issue and
// popped when the EX/MEM register is expected to show them.
module tb_ex_mul_stage;
  import ex_mul_stage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] RS1data_i = '0, RS2data_i = '0, Imm_i = '0;
  logic        ALUSrc_i = 1'b0;
  logic [2:0]  ALUCtrl_i = 3'b011;
  logic        RegWrite_i = 1'b0, MemtoReg_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0;
  logic [4:0]  Rd_i = '0;
  logic [1:0]  Forward_A_i = '0, Forward_B_i = '0;
  logic [31:0] MEM_ALUResult_i = '0, WB_WriteData_i = '0;
  logic        Stall_o;
  logic [31:0] ALUResult_o, MemData_o;
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
  logic [4:0]  Rd_o;

  ex_mul_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .ALUSrc_i(ALUSrc_i),
    .ALUCtrl_i(ALUCtrl_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .Rd_i(Rd_i),
    .Forward_A_i(Forward_A_i), .Forward_B_i(Forward_B_i),
    .MEM_ALUResult_i(MEM_ALUResult_i), .WB_WriteData_i(WB_WriteData_i),
    .Stall_o(Stall_o), .ALUResult_o(ALUResult_o), .MemData_o(MemData_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .Rd_o(Rd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      3'b000:         return a & b;
      3'b001:         return a ^ b;
      3'b010:         return a << sh;
      3'b011, 3'b110: return a + b;
      3'b100:         return a - b;
      3'b101:         return a * b;
      default:        return $signed(a) >>> sh;
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] mem, input logic [31:0] wb, input logic [4:0] rd);
    ALUCtrl_i = op;  RS1data_i = rs1;  RS2data_i = rs2;
    Forward_A_i = fa;  Forward_B_i = fb;
    MEM_ALUResult_i = mem;  WB_WriteData_i = wb;  Rd_i = rd;
    ALUSrc_i = 1'b0;  Imm_i = 32'h5A5A_0F0F;
    RegWrite_i = 1'b1;  MemtoReg_i = 1'b0;  MemRead_i = 1'b0;  MemWrite_i = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_res"}, ALUResult_o, e.res);
      chk({tag, "_rd"}, 32'(Rd_o), 32'(e.rd));
      chk({tag, "_rw"}, 32'(RegWrite_o), 32'(e.rw));
    end
  endtask

  task automatic exec_single(input string tag, input logic [31:0] exp_res);
    exp_t e;
    e.res = exp_res;  e.rd = Rd_i;  e.rw = RegWrite_i;
    sb.push_back(e);
    #1;
    chk({tag, "_stall"}, 32'(Stall_o), 32'd0);
    @(posedge clk_i); #1;
    pop_check(tag);
  endtask

  task automatic alu_case(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic src, input logic [4:0] rd);
    drive(op, a, src ? 32'hDEAD_BEEF : b, 2'b00, 2'b00, 32'h0, 32'h0, rd);
    ALUSrc_i = src;
    if (src) Imm_i = b;
    exec_single(tag, model(op, a, b));
  endtask

  task automatic run_mul(input string tag, input logic [31:0] exp_res, input bit jitter);
    exp_t e;
    int   stalls = 0;
    int   n      = 0;
    bit   done   = 1'b0;
    e.res = exp_res;  e.rd = Rd_i;  e.rw = RegWrite_i;
    sb.push_back(e);
    while (!done && n < 40) begin
      #1;
      if (Stall_o) begin
        stalls++;
        @(posedge clk_i); #1;
        chk({tag, "_bubble_rw"}, 32'(RegWrite_o), 32'd0);
        if (jitter) begin
          MEM_ALUResult_i = $urandom;
          WB_WriteData_i  = $urandom;
        end
      end else begin
        @(posedge clk_i); #1;
        done = 1'b1;
      end
      n++;
    end
    chk({tag, "_completed"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'd33);
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_alu", ALUResult_o, 32'h0);
    chk("rst_memdata", MemData_o, 32'h0);
    chk("rst_rd", 32'(Rd_o), 32'h0);
    chk("rst_ctrl", 32'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}), 32'h0);
    chk("rst_stall", 32'(Stall_o), 32'h0);
    rst_i = 1'b1;

    // Forwarding and single-cycle ALU
    drive(3'b011, 32'd99, 32'd7, 2'b10, 2'b00, 32'd5, 32'd0, 5'd3);
    exec_single("add_fwd_mem", 32'd12);
    drive(3'b100, 32'd1, 32'd50, 2'b11, 2'b01, 32'd100, 32'd3, 5'd4);
    exec_single("sub_fwd_wb", 32'hFFFF_FFFE);
    alu_case("and",  3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 5'd5);
    alu_case("xor",  3'b001, 32'hA5A5_A5A5, 32'h0F0F_00FF, 1'b0, 5'd6);
    alu_case("sll",  3'b010, 32'h8000_0123, 32'h0000_0024, 1'b0, 5'd7);
    alu_case("srai", 3'b111, 32'h8000_0010, 32'h0000_0003, 1'b1, 5'd8);
    alu_case("addi", 3'b110, 32'd3, 32'hFFFF_FFFB, 1'b1, 5'd9);

    // Store: operand B from immediate, store data still the forwarded RS2
    drive(3'b011, 32'h100, 32'hAA, 2'b00, 2'b10, 32'h55, 32'h0, 5'd0);
    ALUSrc_i = 1'b1;  Imm_i = 32'h8;  RegWrite_i = 1'b0;  MemWrite_i = 1'b1;
    exec_single("store", 32'h108);
    chk("store_memdata", MemData_o, 32'h55);
    chk("store_memwrite", 32'(MemWrite_o), 32'd1);

    // Multiplies
    drive(3'b101, 32'd6, 32'd7, 2'b00, 2'b00, 32'd0, 32'd0, 5'd10);
    run_mul("mul_6x7", 32'd42, 1'b0);
    drive(3'b101, 32'd0, 32'd999, 2'b10, 2'b01, 32'd13, 32'd11, 5'd11);
    run_mul("mul_fwd_jitter", model(3'b101, 32'd13, 32'd11), 1'b1);
    drive(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2'b00, 32'd0, 32'd0, 5'd12);
    run_mul("mul_ones", 32'h0000_0001, 1'b0);
    drive(3'b101, 32'd3, 32'd4, 2'b00, 2'b00, 32'd0, 32'd0, 5'd13);
    run_mul("mul_b2b", 32'd12, 1'b0);
    drive(3'b101, 32'h1234_5678, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd14);
    run_mul("mul_x0", 32'd0, 1'b0);
    drive(3'b101, 32'd0, 32'hABCD_0001, 2'b00, 2'b00, 32'd0, 32'd0, 5'd15);
    run_mul("mul_0x", 32'd0, 1'b0);
    drive(3'b101, 32'hFFFF_FFF9, 32'd6, 2'b00, 2'b00, 32'd0, 32'd0, 5'd16);
    run_mul("mul_neg", model(3'b101, 32'hFFFF_FFF9, 32'd6), 1'b0);

    // Reset in the middle of a MUL (counter at 10)
    drive(3'b101, 32'd5, 32'd6, 2'b00, 2'b00, 32'd0, 32'd0, 5'd17);
    @(posedge clk_i);
    repeat (10) @(posedge clk_i);
    #1;
    chk("midrst_stall_before", 32'(Stall_o), 32'd1);
    rst_i = 1'b0;  ALUCtrl_i = 3'b011;  RegWrite_i = 1'b0;
    @(posedge clk_i); #1;
    chk("midrst_alu", ALUResult_o, 32'h0);
    chk("midrst_memdata", MemData_o, 32'h0);
    chk("midrst_rd", 32'(Rd_o), 32'h0);
    chk("midrst_ctrl", 32'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}), 32'h0);
    chk("midrst_stall", 32'(Stall_o), 32'h0);
    rst_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i); #1;
      chk("midrst_no_write", 32'(RegWrite_o), 32'd0);
    end
    drive(3'b011, 32'd2, 32'd2, 2'b00, 2'b00, 32'd0, 32'd0, 5'd18);
    exec_single("add_after_rst", 32'd4);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mul_stage.md
EX_MUL_STAGE -- requirements
Module: ex_mul_stage

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i, input, 1, reset; it is synchronous and active-low.
REQ-003 SHALL have ports RS1data_i and RS2data_i, inputs, 32 each, register-file operands from the ID/EX register.
REQ-004 SHALL have port Imm_i, input, 32, sign-extended immediate; ALUSrc_i, input, 1, selects Imm_i as operand B.
REQ-005 SHALL have port ALUCtrl_i, input, 3, operation code (encodings in package).
REQ-006 SHALL have ports RegWrite_i, MemtoReg_i, MemRead_i and MemWrite_i, inputs, 1 each; Rd_i, input, 5; all ID/EX control fields.
REQ-007 SHALL have ports Forward_A_i and Forward_B_i, inputs, 2 each, forwarding selects from the forwarding unit.
REQ-008 SHALL have port MEM_ALUResult_i, input, 32, value at the MEM stage; WB_WriteData_i, input, 32, value at the WB stage.
REQ-009 SHALL have port Stall_o, output, 1; when high, PC, IF/ID and ID/EX hold.
REQ-010 SHALL have ports ALUResult_o, output, 32, and MemData_o, output, 32, the EX/MEM registered result and store data.
REQ-011 SHALL have ports RegWrite_o, MemtoReg_o, MemRead_o and MemWrite_o, outputs, 1 each; Rd_o, output, 5; all EX/MEM registered.

Function
REQ-012 SHALL pick each forwarded operand by select: 00 gives the register value, 10 gives MEM_ALUResult_i, 01 gives WB_WriteData_i, and 11 is treated as 00.
REQ-013 SHALL form operand B as Imm_i when ALUSrc_i=1, else the forwarded RS2; MemData_o SHALL always take the forwarded RS2.
REQ-014 SHALL execute AND, XOR, SLL (shift by B[4:0]), ADD, SUB and SRAI (arithmetic shift by B[4:0]) in one cycle, with 32-bit wrap-around arithmetic.
REQ-015 SHALL execute MUL iteratively by shift-add and return the low 32 bits of A*B, with the sign handled implicitly through two's-complement wrap.
REQ-016 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-017 SHALL, in IDLE with ALUCtrl_i=MUL: assert Stall_o combinationally, latch the forwarded A and B, clear the counter, clear the accumulator and go to BUSY.
REQ-018 SHALL, in BUSY: perform one iteration per cycle (acc += a when b[0]=1; a <<= 1; b >>= 1) and increment the counter; after counter=31, go to DONE; Stall_o SHALL stay high throughout BUSY.
REQ-019 SHALL, in DONE: deassert Stall_o, load the accumulator and the held ID/EX control fields into EX/MEM, and go to IDLE.
REQ-020 SHALL give MUL 34 cycles in EX: Stall_o is high for 33 cycles and the result is latched at the end of the 34th.
REQ-021 SHALL load a bubble into EX/MEM (all four control outputs 0; data outputs and Rd_o don't-care) on every cycle in which Stall_o=1.
REQ-022 SHALL use only the operands latched in REQ-017 for the MUL, so that MEM/WB values changing while bubbles drain cannot corrupt the product.
REQ-023 SHALL, when not stalled and not MUL, load EX/MEM every cycle with a latency of 1 cycle.
REQ-024 SHALL handle back-to-back MULs: a MUL arriving in the cycle after DONE starts a new IDLE->BUSY sequence, with no lost or merged operands.
REQ-025 SHALL make MUL x,0 and MUL 0,x return 0, and MUL 0xFFFFFFFF,0xFFFFFFFF return 0x00000001.

Reset
REQ-026 SHALL, when rst_i=0 at a clock edge, set state to IDLE and clear the counter, accumulator, ALUResult_o, MemData_o and Rd_o, and all four control outputs, to 0.
REQ-027 SHALL, on reset during BUSY or DONE, abandon the MUL with no EX/MEM write; Stall_o SHALL be 0 in the cycle after reset, unless a MUL is present.

Structure
REQ-028 SHALL place the following in a shared package: the ALUCtrl encodings (AND=000, XOR=001, SLL=010, ADD=011, SUB=100, MUL=101, ADDI=110 treated as ADD, SRAI=111), the forward-select encodings and MUL_CYCLES=32.
REQ-029 SHALL place the iterative multiplier (counter, acc/a/b registers, start/done) in a sub-module mul_iter; muxes, FSM and EX/MEM register SHALL stay in ex_mul_stage.

Verification
REQ-030 SHALL cover ADD with Forward_A=10, MEM_ALUResult=5, RS2=7 -> ALUResult_o=12 one cycle later, with Stall_o=0.
REQ-031 SHALL cover SUB with Forward_B=01, WB_WriteData=3, RS1=1 -> ALUResult_o=0xFFFFFFFE; with Forward_A=11, the RS1 operand is used.
REQ-032 SHALL cover MUL of 6 by 7 -> Stall_o high for exactly 33 cycles, ALUResult_o=42 and RegWrite_o=1 at DONE+1, and RegWrite_o=0 throughout the stall.
REQ-033 SHALL cover MUL with MEM_ALUResult_i changing every cycle after start -> the product uses only the start-cycle operands.
REQ-034 SHALL cover rst_i=0 at BUSY counter=10 -> all outputs 0 next cycle and no result ever written; a following ADD 2+2 gives 4.
REQ-035 SHALL cover MUL 0xFFFFFFFF by 0xFFFFFFFF followed immediately by MUL 3 by 4 -> results 1 then 12, each with its own Rd_o.
